ts_os_rcvr_mlane: RTL and testbench

//  Multi-lane TS1/TS2 ordered-set receiver on the MAC->PHY tx symbol path. Per lane: frames 16-symbol
//  OS on COM, classifies TS1/TS2 by identifier symbols, captures link/lane/N_FTS/rate/control fields,

---
 rtl/ts_os_rcvr_mlane_if.sv | 47 ++++
 rtl/ts_os_rcvr_mlane.sv | 170 +++++++++++++++++
 tb/tb_ts_os_rcvr_mlane.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_os_rcvr_mlane_if.sv
`default_nettype none
// ============================================================================
// Module : ts_os_rcvr_mlane_if
// Brief  : Symbol-in / ordered-set-out bundle for the multi-lane TS1/TS2 receiver.
//          o_err_cnt exists only when TS_RCVR_ERRCNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
interface ts_os_rcvr_mlane_if #(
  parameter int LANES = 1,
  parameter int CNT_W = 4
);
  logic                   i_en_n;
  logic [LANES*8-1:0]     i_txdata;
  logic [LANES-1:0]       i_txdatak;
  logic [LANES-1:0]       o_os_valid;
  logic [LANES-1:0]       o_os_is_ts2;
  logic [LANES*8-1:0]     o_ts_link;
  logic [LANES*8-1:0]     o_ts_lane;
  logic [LANES*8-1:0]     o_ts_nfts;
  logic [LANES*8-1:0]     o_ts_rate;
  logic [LANES*8-1:0]     o_ts_ctrl;
  logic [LANES*CNT_W-1:0] o_ts_cnt;
  logic [LANES-1:0]       o_ts_consec;
  logic [LANES-1:0]       o_os_err;
`ifdef TS_RCVR_ERRCNT_EN
  logic [LANES*8-1:0]     o_err_cnt;
`endif

  modport master (
    output i_en_n, i_txdata, i_txdatak,
    input  o_os_valid, o_os_is_ts2, o_ts_link, o_ts_lane, o_ts_nfts,
           o_ts_rate, o_ts_ctrl, o_ts_cnt, o_ts_consec, o_os_err
`ifdef TS_RCVR_ERRCNT_EN
    , input o_err_cnt
`endif
  );

  modport slave (
    input  i_en_n, i_txdata, i_txdatak,
    output o_os_valid, o_os_is_ts2, o_ts_link, o_ts_lane, o_ts_nfts,
           o_ts_rate, o_ts_ctrl, o_ts_cnt, o_ts_consec, o_os_err
`ifdef TS_RCVR_ERRCNT_EN
    , output o_err_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/ts_os_rcvr_mlane.sv
`default_nettype none
// ============================================================================
// Module : ts_os_rcvr_mlane
// Brief  : Per-lane TS1/TS2 ordered-set framer/classifier with consecutive-TS
//          counting. Optional macro TS_RCVR_ERRCNT_EN adds per-lane error counters.
// Rev    : 1.0  initial release
// ============================================================================
module ts_os_rcvr_mlane #(
  parameter int          LANES      = 1,
  parameter int          CNT_W      = 4,
  parameter int unsigned CONSEC_REQ = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  ts_os_rcvr_mlane_if.slave    bus
);

  localparam logic [7:0] c_COM    = 8'hBC;
  localparam logic [7:0] c_PAD    = 8'hF7;
  localparam logic [7:0] c_TS1_ID = 8'h4A;
  localparam logic [7:0] c_TS2_ID = 8'h45;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_COLL = 1'b1
  } state_t;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic             w_k;
    logic [7:0]       w_d;
    logic             w_is_com;
    state_t           r_state, w_state_n;
    logic [3:0]       r_idx, w_idx_n;
    logic             r_ts1_ok, r_ts2_ok, w_ts1_ok_n, w_ts2_ok_n;
    logic             w_store, w_valid, w_err, w_is_ts2, w_same;
    logic [5:1][7:0]  r_sym;
    logic [5:1][7:0]  r_f;
    logic             r_os_valid, r_is_ts2, r_os_err, r_prev_ok;
    logic [CNT_W-1:0] r_cnt;

    assign w_k      = bus.i_txdatak[l];
    assign w_d      = bus.i_txdata[8*l +: 8];
    assign w_is_com = w_k && (w_d == c_COM);

    always_comb begin
      w_state_n  = r_state;
      w_idx_n    = r_idx;
      w_ts1_ok_n = r_ts1_ok;
      w_ts2_ok_n = r_ts2_ok;
      w_store    = 1'b0;
      w_valid    = 1'b0;
      w_err      = 1'b0;
      w_is_ts2   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_com) begin
            w_state_n  = S_COLL;
            w_idx_n    = 4'd1;
            w_ts1_ok_n = 1'b1;
            w_ts2_ok_n = 1'b1;
          end
        end
        S_COLL: begin
          // A COM inside an OS aborts it but also starts the next one.
          if (w_is_com) begin
            w_err      = 1'b1;
            w_idx_n    = 4'd1;
            w_ts1_ok_n = 1'b1;
            w_ts2_ok_n = 1'b1;
          end else if (w_k && !(((r_idx == 4'd1) || (r_idx == 4'd2)) && (w_d == c_PAD))) begin
            w_err     = 1'b1;
            w_state_n = S_IDLE;
            w_idx_n   = 4'd0;
          end else begin
            w_store = 1'b1;
            w_idx_n = r_idx + 4'd1;
            if (r_idx >= 4'd6) begin
              w_ts1_ok_n = r_ts1_ok && (w_d == c_TS1_ID);
              w_ts2_ok_n = r_ts2_ok && (w_d == c_TS2_ID);
            end
            if (r_idx == 4'd15) begin
              w_state_n = S_IDLE;
              w_idx_n   = 4'd0;
              if (w_ts1_ok_n) begin
                w_valid = 1'b1;
              end else if (w_ts2_ok_n) begin
                w_valid  = 1'b1;
                w_is_ts2 = 1'b1;
              end else begin
                w_err = 1'b1;
              end
            end
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_idx_n   = 4'd0;
        end
      endcase
    end

    assign w_same = r_prev_ok && (r_is_ts2 == w_is_ts2) && (r_f == r_sym);

    always_ff @(posedge clk) begin
      if (reset || bus.i_en_n) begin
        r_state    <= S_IDLE;
        r_idx      <= 4'd0;
        r_ts1_ok   <= 1'b0;
        r_ts2_ok   <= 1'b0;
        r_sym      <= '0;
        r_f        <= '0;
        r_os_valid <= 1'b0;
        r_is_ts2   <= 1'b0;
        r_os_err   <= 1'b0;
        r_prev_ok  <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_state    <= w_state_n;
        r_idx      <= w_idx_n;
        r_ts1_ok   <= w_ts1_ok_n;
        r_ts2_ok   <= w_ts2_ok_n;
        r_os_valid <= w_valid;
        r_os_err   <= w_err;
        if (w_store && (r_idx <= 4'd5)) begin
          r_sym[r_idx[2:0]] <= w_d;
        end
        if (w_valid) begin
          r_is_ts2  <= w_is_ts2;
          r_f       <= r_sym;
          r_prev_ok <= 1'b1;
          if (!w_same) begin
            r_cnt <= CNT_W'(1);
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (w_err) begin
          r_prev_ok <= 1'b0;
          r_cnt     <= '0;
        end
      end
    end

    assign bus.o_os_valid[l]             = r_os_valid;
    assign bus.o_os_is_ts2[l]            = r_is_ts2;
    assign bus.o_os_err[l]               = r_os_err;
    assign bus.o_ts_link[8*l +: 8]       = r_f[1];
    assign bus.o_ts_lane[8*l +: 8]       = r_f[2];
    assign bus.o_ts_nfts[8*l +: 8]       = r_f[3];
    assign bus.o_ts_rate[8*l +: 8]       = r_f[4];
    assign bus.o_ts_ctrl[8*l +: 8]       = r_f[5];
    assign bus.o_ts_cnt[CNT_W*l +: CNT_W] = r_cnt;
    assign bus.o_ts_consec[l]            = ({{(32-CNT_W){1'b0}}, r_cnt} >= 32'(CONSEC_REQ));

`ifdef TS_RCVR_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
      if (reset || bus.i_en_n) begin
        r_err_cnt <= 8'd0;
      end else if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end

    assign bus.o_err_cnt[8*l +: 8] = r_err_cnt;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_ts_os_rcvr_mlane.sv
`default_nettype none
// ============================================================================
// Module : tb_ts_os_rcvr_mlane
// Brief  : Scoreboard bench for ts_os_rcvr_mlane (4 lanes, 4-bit counters).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ts_os_rcvr_mlane;
  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CREQ  = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int GUARD = 4000;

  typedef struct packed {logic k; logic [7:0] d;} sym_t;
  typedef struct {
    bit          err;
    bit          ts2;
    logic [39:0] f;
    int          cnt;
    int          errs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  sym_t        lane_q [LANES][$];
  exp_t        exp_q  [LANES][$];
  bit          m_ok   [LANES];
  bit          m_ts2  [LANES];
  logic [39:0] m_f    [LANES];
  int          m_cnt  [LANES];
  int          m_errs [LANES];

  ts_os_rcvr_mlane_if #(.LANES(LANES), .CNT_W(CNT_W)) u_bus ();

  ts_os_rcvr_mlane #(.LANES(LANES), .CNT_W(CNT_W), .CONSEC_REQ(CREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clr_model();
    for (int l = 0; l < LANES; l++) begin
      m_ok[l] = 1'b0; m_ts2[l] = 1'b0; m_f[l] = '0; m_cnt[l] = 0; m_errs[l] = 0;
      lane_q[l].delete();
      exp_q[l].delete();
    end
  endtask

  task automatic expect_err(input int l);
    exp_t e;
    m_ok[l]  = 1'b0;
    m_cnt[l] = 0;
    if (m_errs[l] < 255) m_errs[l]++;
    e.err = 1'b1; e.ts2 = 1'b0; e.f = '0; e.cnt = 0; e.errs = m_errs[l];
    exp_q[l].push_back(e);
  endtask

  task automatic push_idle(input int l, input int n);
    for (int i = 0; i < n; i++) lane_q[l].push_back({1'b0, 8'h00});
  endtask

  // Leading part of an OS (COM plus n-1 good symbols) with no expectation.
  task automatic push_partial(input int l, input int n);
    lane_q[l].push_back({1'b1, 8'hBC});
    for (int i = 1; i < n; i++) lane_q[l].push_back({1'b0, 8'(8'h10 + i)});
  endtask

  task automatic push_os(input int l, input bit ts2, input logic [39:0] f, input bit pad1,
                         input int bad_at, input sym_t bad);
    sym_t s [16];
    exp_t e;
    logic [7:0] id;
    bit same;
    id   = ts2 ? 8'h45 : 8'h4A;
    s[0] = {1'b1, 8'hBC};
    s[1] = pad1 ? {1'b1, 8'hF7} : {1'b0, f[7:0]};
    for (int i = 2; i <= 5; i++) s[i] = {1'b0, f[8*(i-1) +: 8]};
    for (int i = 6; i <= 15; i++) s[i] = {1'b0, id};
    if (bad_at >= 0) s[bad_at] = bad;
    for (int i = 0; i < 16; i++) lane_q[l].push_back(s[i]);
    if (bad_at >= 0) begin
      expect_err(l);
    end else begin
      e.err = 1'b0;
      e.ts2 = ts2;
      e.f   = pad1 ? {f[39:8], 8'hF7} : f;
      same  = m_ok[l] && (m_ts2[l] == ts2) && (m_f[l] == e.f);
      m_cnt[l] = same ? ((m_cnt[l] >= CMAX) ? CMAX : m_cnt[l] + 1) : 1;
      m_ok[l]  = 1'b1;
      m_ts2[l] = ts2;
      m_f[l]   = e.f;
      e.cnt    = m_cnt[l];
      e.errs   = m_errs[l];
      exp_q[l].push_back(e);
    end
  endtask

  task automatic step();
    sym_t s;
    for (int l = 0; l < LANES; l++) begin
      s = (lane_q[l].size() > 0) ? lane_q[l].pop_front() : {1'b0, 8'h00};
      u_bus.i_txdatak[l]       = s.k;
      u_bus.i_txdata[8*l +: 8] = s.d;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int sym_left();
    int n = 0;
    for (int l = 0; l < LANES; l++) n += lane_q[l].size();
    return n;
  endfunction

  function automatic int exp_left();
    int n = 0;
    for (int l = 0; l < LANES; l++) n += exp_q[l].size();
    return n;
  endfunction

  task automatic drain(input string tag);
    int guard = 0;
    while (sym_left() > 0 && guard < GUARD) begin
      step();
      guard++;
    end
    repeat (3) step();
    chk_eq({tag, "_timeout"}, 64'(guard >= GUARD), 64'd0);
    chk_eq({tag, "_pending"}, 64'(exp_left()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (u_bus.o_os_valid[l] || u_bus.o_os_err[l]) begin
          if (exp_q[l].size() == 0) begin
            chk_eq($sformatf("unexpected_evt_l%0d", l), {u_bus.o_os_valid[l], u_bus.o_os_err[l]}, 64'd0);
          end else begin
            exp_t e;
            int c;
            e = exp_q[l].pop_front();
            c = int'(u_bus.o_ts_cnt[CNT_W*l +: CNT_W]);
            chk_eq($sformatf("evt_kind_l%0d", l), {u_bus.o_os_valid[l], u_bus.o_os_err[l]},
                   e.err ? 64'd1 : 64'd2);
            chk_eq($sformatf("ts_cnt_l%0d", l), 64'(c), 64'(e.cnt));
            chk_eq($sformatf("ts_consec_l%0d", l), 64'(u_bus.o_ts_consec[l]), 64'(e.cnt >= CREQ));
`ifdef TS_RCVR_ERRCNT_EN
            chk_eq($sformatf("err_cnt_l%0d", l), 64'(u_bus.o_err_cnt[8*l +: 8]), 64'(e.errs));
`endif
            if (!e.err) begin
              chk_eq($sformatf("is_ts2_l%0d", l), 64'(u_bus.o_os_is_ts2[l]), 64'(e.ts2));
              chk_eq($sformatf("fields_l%0d", l),
                     {u_bus.o_ts_ctrl[8*l +: 8], u_bus.o_ts_rate[8*l +: 8], u_bus.o_ts_nfts[8*l +: 8],
                      u_bus.o_ts_lane[8*l +: 8], u_bus.o_ts_link[8*l +: 8]}, 64'(e.f));
            end
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_valid"},  64'(u_bus.o_os_valid),  64'd0);
    chk_eq({tag, "_err"},    64'(u_bus.o_os_err),    64'd0);
    chk_eq({tag, "_ts2"},    64'(u_bus.o_os_is_ts2), 64'd0);
    chk_eq({tag, "_link"},   64'(u_bus.o_ts_link),   64'd0);
    chk_eq({tag, "_nfts"},   64'(u_bus.o_ts_nfts),   64'd0);
    chk_eq({tag, "_cnt"},    64'(u_bus.o_ts_cnt),    64'd0);
    chk_eq({tag, "_consec"}, 64'(u_bus.o_ts_consec), 64'd0);
`ifdef TS_RCVR_ERRCNT_EN
    chk_eq({tag, "_errcnt"}, 64'(u_bus.o_err_cnt),   64'd0);
`endif
  endtask

  localparam logic [39:0] F_A = {8'h00, 8'h02, 8'h20, 8'h00, 8'h01};
  localparam logic [39:0] F_B = {8'h08, 8'h01, 8'h30, 8'h03, 8'h05};
  localparam logic [39:0] F_C = {8'h08, 8'h01, 8'h30, 8'h04, 8'h05};

  initial begin
    sym_t nb;
    nb = {1'b0, 8'h00};
    reset = 1'b1;
    u_bus.i_en_n = 1'b0;
    u_bus.i_txdata = '0;
    u_bus.i_txdatak = '0;
    clr_model();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // 8 identical TS1 back-to-back, then 3 more TS1 and a TS2 with same fields
    for (int i = 0; i < 11; i++) push_os(0, 1'b0, F_A, 1'b0, -1, nb);
    push_os(0, 1'b1, F_A, 1'b0, -1, nb);
    drain("ts1_run");

    // COM at index 7 aborts, the restarted OS is valid; then a bad ID at symbol 10
    push_partial(0, 7);
    expect_err(0);
    push_os(0, 1'b0, F_A, 1'b0, -1, nb);
    push_os(0, 1'b0, F_A, 1'b0, 10, {1'b0, 8'h45});
    push_os(0, 1'b0, F_A, 1'b0, -1, nb);
    drain("abort");

    // saturation on lane 1, field change restarts; PAD link on lane 2
    for (int i = 0; i < 17; i++) push_os(1, 1'b1, F_B, 1'b0, -1, nb);
    push_os(1, 1'b1, F_C, 1'b0, -1, nb);
    push_os(2, 1'b0, F_B, 1'b1, -1, nb);
    push_os(2, 1'b0, F_B, 1'b1, -1, nb);
    drain("sat_pad");

    // staggered lanes, lane 3 gets an illegal K symbol at index 3
    for (int l = 0; l < LANES; l++) begin
      push_idle(l, l);
      if (l == 3) push_os(l, 1'b0, F_C, 1'b0, 3, {1'b1, 8'h1C});
      else push_os(l, 1'b1, F_C, 1'b0, -1, nb);
      push_os(l, 1'b1, F_C, 1'b0, -1, nb);
    end
    drain("stagger");

    // en_n mid-OS: partial discarded silently, counters cleared
    push_partial(0, 9);
    repeat (5) step();
    u_bus.i_en_n = 1'b1;
    step();
    chk_all_zero("en_n");
    step();
    u_bus.i_en_n = 1'b0;
    clr_model();
    push_os(0, 1'b0, F_A, 1'b0, -1, nb);
    drain("after_en");

    // reset mid-OS on staggered lanes
    for (int l = 0; l < LANES; l++) push_os(l, 1'b0, F_B, 1'b0, -1, nb);
    drain("pre_rst");
    for (int l = 0; l < LANES; l++) begin
      push_idle(l, l);
      push_partial(l, 12);
    end
    repeat (8) step();
    reset = 1'b1;
    step();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    clr_model();
    push_os(2, 1'b0, F_B, 1'b0, -1, nb);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
